// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity-mode codes, FSM state
// codes and the bit-period helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with the head word visible combinationally on rd_data.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO; frames are sent LSB-first with optional
// parity and 1 or 2 stop bits, back-to-back while words are queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 27_000_000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_resetn,
    input  logic                          i_valid,
    input  logic [PAYLOAD_BITS-1:0]       i_data,
    output logic                          o_ready,
    input  logic [1:0]                    i_parity_mode,
    input  logic                          i_two_stop,
    output logic                          o_uart_txd,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned CNT_W    = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(PAYLOAD_BITS - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              bit_idx;
    logic                    stop_idx;
    logic [PAYLOAD_BITS-1:0] shift;
    logic                    par_bit;
    logic                    par_en;
    logic                    two_stop;
    logic                    txd;

    logic [PAYLOAD_BITS-1:0] head;
    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    bit_end;
    logic                    last_stop;

    sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) fifo (
        .clk     (i_clk),
        .resetn  (i_resetn),
        .push    (i_valid),
        .pop     (pop),
        .wr_data (i_data),
        .rd_data (head),
        .level   (o_fifo_level),
        .full    (full),
        .empty   (empty)
    );

    assign o_ready    = !full;
    assign o_busy     = (state != ST_IDLE);
    assign o_uart_txd = txd;

    assign bit_end   = (cnt == CNT_LAST);
    assign last_stop = (state == ST_STOP) && bit_end && (stop_idx == two_stop);
    assign pop       = !empty && ((state == ST_IDLE) || last_stop);

    // txd is loaded with the level of the bit the FSM is entering, so the pin
    // changes on the same edge as the state.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            two_stop <= 1'b0;
            txd      <= 1'b1;
        end else if (pop) begin
            state    <= ST_START;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= head;
            par_en   <= (i_parity_mode == PAR_EVEN) || (i_parity_mode == PAR_ODD);
            par_bit  <= (^head) ^ (i_parity_mode == PAR_ODD);
            two_stop <= i_two_stop;
            txd      <= 1'b0;
        end else if (state != ST_IDLE) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (bit_end) begin
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        txd   <= shift[0];
                    end
                    ST_DATA: begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == BIT_LAST) begin
                            if (par_en) begin
                                state <= ST_PARITY;
                                txd   <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            txd <= shift[1];
                        end
                    end
                    ST_PARITY: begin
                        state    <= ST_STOP;
                        stop_idx <= 1'b0;
                        txd      <= 1'b1;
                    end
                    ST_STOP: begin
                        txd <= 1'b1;
                        if (stop_idx == two_stop) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        txd   <= 1'b1;
                    end
                endcase
            end
        end else begin
            txd <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a queue-based line model checked every
// cycle, plus literal checks on bit values, frame lengths and handshakes.
module tb_uart_tx_fifo;

    localparam int unsigned CPB   = 10;
    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic [1:0] pmode;
    logic       two_stop;
    logic       txd;
    logic       busy;
    logic [4:0] level;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_HZ       (1_000_000),
        .BIT_RATE     (100_000),
        .PAYLOAD_BITS (8),
        .FIFO_DEPTH   (16)
    ) dut (
        .i_clk         (clk),
        .i_resetn      (resetn),
        .i_valid       (valid),
        .i_data        (data),
        .o_ready       (ready),
        .i_parity_mode (pmode),
        .i_two_stop    (two_stop),
        .o_uart_txd    (txd),
        .o_busy        (busy),
        .o_fifo_level  (level)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: queued words plus the per-cycle line levels of the frame on the pin.
    logic [7:0] mq[$];
    bit         lq[$];
    bit         started = 1'b0;
    int         exp_txd, exp_busy, exp_level, exp_ready;

    task automatic add_frame(input logic [7:0] d, input logic [1:0] mode, input logic two);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (mode == 2'b01) bits.push_back(^d);
        else if (mode == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        foreach (bits[i]) for (int k = 0; k < CPB; k++) lq.push_back(bits[i]);
    endtask

    always @(posedge clk) begin
        bit accept;
        if (!resetn) begin
            mq.delete();
            lq.delete();
        end else begin
            accept = valid && (mq.size() < DEPTH);
            if (lq.size() > 0) void'(lq.pop_front());
            if (lq.size() == 0 && mq.size() > 0) add_frame(mq.pop_front(), pmode, two_stop);
            if (accept) mq.push_back(data);
        end
        exp_txd   = (lq.size() > 0) ? int'(lq[0]) : 1;
        exp_busy  = (lq.size() > 0) ? 1 : 0;
        exp_level = mq.size();
        exp_ready = (mq.size() < DEPTH) ? 1 : 0;
        started   = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("txd",   int'(txd),   exp_txd);
            check("busy",  int'(busy),  exp_busy);
            check("level", int'(level), exp_level);
            check("ready", int'(ready), exp_ready);
        end
    end

    // Lengths of contiguous busy-high stretches, observed on the DUT.
    int cur_run = 0;
    int runs[$];
    always @(negedge clk) begin
        if (started) begin
            if (busy === 1'b1) cur_run++;
            else if (cur_run > 0) begin
                runs.push_back(cur_run);
                cur_run = 0;
            end
        end
    end

    task automatic finish_frames(input string name, input int exp_len);
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, int'(n < 5000), 1);
        repeat (3) @(negedge clk);
        check({name, "_busy_len"}, (runs.size() == 1) ? runs[0] : -1, exp_len);
        runs.delete();
    endtask

    int t1_bits[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        int accepted;
        int busy_seen;
        resetn   = 1'b0;
        valid    = 1'b0;
        data     = '0;
        pmode    = 2'b00;
        two_stop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_txd",   int'(txd),   1);
        check("rst_busy",  int'(busy),  0);
        check("rst_level", int'(level), 0);
        check("rst_ready", int'(ready), 1);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 0x55, no parity, one stop
        valid = 1'b1; data = 8'h55;
        @(negedge clk); valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c % 10 == 5) check("t1_bit", int'(txd), t1_bits[c / 10]);
        end
        finish_frames("t1", 100);

        // 2: 0xA3 even/one stop, then 0xA3 odd/two stops
        pmode = 2'b01; two_stop = 1'b0; valid = 1'b1; data = 8'hA3;
        @(negedge clk); valid = 1'b0;
        for (int c = 0; c < 230; c++) begin
            @(negedge clk);
            if (c == 0) begin
                pmode = 2'b10; two_stop = 1'b1; valid = 1'b1; data = 8'hA3;
            end
            if (c == 1) valid = 1'b0;
            if (c == 95) check("t2_even_parity", int'(txd), 0);
            if (c == 205) check("t2_odd_parity", int'(txd), 1);
        end
        finish_frames("t2", 230);

        // 3: 20 consecutive pushes into an idle transmitter
        pmode = 2'b00; two_stop = 1'b0; accepted = 0;
        for (int k = 0; k < 20; k++) begin
            valid = 1'b1; data = 8'(k * 7 + 1);
            if (ready === 1'b1) accepted++;
            if (k == 17) check("t3_ready_at_18th", int'(ready), 0);
            @(negedge clk);
        end
        valid = 1'b0;
        check("t3_accepted", accepted, 17);
        finish_frames("t3", 1700);

        // 4: push coinciding with the STOP-to-START pop at level 1
        valid = 1'b1; data = 8'h11;
        @(negedge clk); data = 8'h22;
        for (int c = 2; c <= 102; c++) begin
            @(negedge clk);
            if (c == 2) valid = 1'b0;
            if (c == 101) begin
                check("t4_level_before", int'(level), 1);
                valid = 1'b1; data = 8'h33;
            end
            if (c == 102) begin
                valid = 1'b0;
                check("t4_level_after", int'(level), 1);
                check("t4_busy_after", int'(busy), 1);
            end
        end
        finish_frames("t4", 300);

        // 5: reset during data bit 3 with two words queued
        valid = 1'b1; data = 8'h5A;
        @(negedge clk); data = 8'hC3;
        @(negedge clk); data = 8'h0F;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            if (c == 44) begin
                check("t5_level_before", int'(level), 2);
                resetn = 1'b0;
            end
            if (c == 45) begin
                check("t5_txd",   int'(txd),   1);
                check("t5_busy",  int'(busy),  0);
                check("t5_level", int'(level), 0);
                check("t5_ready", int'(ready), 1);
                resetn = 1'b1;
            end
        end
        busy_seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        check("t5_no_frames_after_reset", busy_seen, 0);
        runs.delete();

        // 6: parity mode changed mid-frame only affects the next frame
        pmode = 2'b00; two_stop = 1'b0; valid = 1'b1; data = 8'h00;
        @(negedge clk); data = 8'h03;
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            if (c == 2) valid = 1'b0;
            if (c == 52) pmode = 2'b10;
            if (c - 2 == 195) check("t6_odd_parity", int'(txd), 1);
        end
        finish_frames("t6", 210);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
